// File: rtl/iob_cache_be_arbiter_iob_pkg.sv
// Shared definitions for the cache back-end arbiter.
//
// Holds the codebase-wide back-end bus widths, the grant FSM encoding
// and the starve-counter width/saturation helper. Imported by the
// arbiter top and available to anything else talking to the back end.
package iob_cache_be_arbiter_iob_pkg;

  // Codebase-wide back-end bus geometry (byte address / data width).
  localparam int IOB_CACHE_IOB_BE_ADDR_W = 24;
  localparam int IOB_CACHE_IOB_BE_DATA_W = 32;

  localparam int STATE_W  = 2;
  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_SAT = 4'd15;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_t;

  // Saturating increment: the counter sticks at 15 instead of wrapping
  // back to 0, which would otherwise hand writes priority again.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == STARVE_SAT) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/iob_reg_ae.sv
// Generic register with asynchronous active-high reset and clock enable.
//
// Ports:
//   clk_i  - clock
//   arst_i - asynchronous reset, active high, loads RST_VAL
//   en_i   - load enable
//   data_i - next value
//   data_o - registered value
module iob_reg_ae #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_cache_be_arbiter_iob.sv
// Cache back-end arbiter: shares one back-end port between the cache
// read (line-fill) channel and the write-through channel.
//
// A registered grant FSM (IDLE/WRITE/READ) picks an owner in IDLE and
// forwards that channel to the back end from the next cycle on. Writes
// win by default; with RD_STARVE_MAX != 0 a waiting read is promoted
// after that many consecutive write grants. A read grant is held until
// rd_busy_i drops so a multi-beat line fill is never interleaved.
//
// Ports:
//   clk_i, reset_i                   - clock, async active-high reset
//   rd_valid_i/rd_addr_i/rd_busy_i   - read request, address, fill in progress
//   rd_ack_o/rd_rdata_o              - read beat ack and data
//   wr_valid_i/wr_addr_i/wr_wdata_i/wr_wstrb_i - write request
//   wr_ack_o                         - write ack
//   be_valid_o/be_addr_o/be_wdata_o/be_wstrb_o - back-end request
//   be_ack_i/be_rdata_i              - back-end response
//   busy_o                           - a grant is active
//   err_o                            - sticky protocol error
module iob_cache_be_arbiter_iob
  import iob_cache_be_arbiter_iob_pkg::*;
#(
  parameter int         BE_ADDR_W     = IOB_CACHE_IOB_BE_ADDR_W,
  parameter int         BE_DATA_W     = IOB_CACHE_IOB_BE_DATA_W,
  parameter logic [3:0] RD_STARVE_MAX = 4'd0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   rd_valid_i,
  input  logic [BE_ADDR_W-1:0]   rd_addr_i,
  input  logic                   rd_busy_i,
  output logic                   rd_ack_o,
  output logic [BE_DATA_W-1:0]   rd_rdata_o,

  input  logic                   wr_valid_i,
  input  logic [BE_ADDR_W-1:0]   wr_addr_i,
  input  logic [BE_DATA_W-1:0]   wr_wdata_i,
  input  logic [BE_DATA_W/8-1:0] wr_wstrb_i,
  output logic                   wr_ack_o,

  output logic                   be_valid_o,
  output logic [BE_ADDR_W-1:0]   be_addr_o,
  output logic [BE_DATA_W-1:0]   be_wdata_o,
  output logic [BE_DATA_W/8-1:0] be_wstrb_o,
  input  logic                   be_ack_i,
  input  logic [BE_DATA_W-1:0]   be_rdata_i,

  output logic                   busy_o,
  output logic                   err_o
);

  logic [STATE_W-1:0]  state_bits;
  arb_state_t          state_q;
  arb_state_t          state_d;
  logic [STARVE_W-1:0] starve_q;
  logic                grant_read;
  logic                grant_write;

  assign state_q = arb_state_t'(state_bits);

  iob_reg_ae #(
    .DATA_W  (STATE_W),
    .RST_VAL (IDLE)
  ) state_reg (
    .clk_i  (clk_i),
    .arst_i (reset_i),
    .en_i   (1'b1),
    .data_i (state_d),
    .data_o (state_bits)
  );

  // Read is chosen when nothing is writing, or when the starve limit is
  // enabled and reached; any other pending write takes the port.
  assign grant_read  = rd_valid_i &&
                       (!wr_valid_i ||
                        ((RD_STARVE_MAX != 4'd0) && (starve_q >= RD_STARVE_MAX)));
  assign grant_write = wr_valid_i && !grant_read;

  // READ only releases when the fill is finished, not on each beat ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_read) begin
          state_d = READ;
        end else if (grant_write) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (be_ack_i) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (!rd_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forwarding mux: only the owning channel reaches the back end; IDLE
  // drives all-zero so nothing leaks out during the decision cycle.
  always_comb begin
    be_valid_o = 1'b0;
    be_addr_o  = '0;
    be_wdata_o = '0;
    be_wstrb_o = '0;
    rd_ack_o   = 1'b0;
    wr_ack_o   = 1'b0;
    case (state_q)
      WRITE: begin
        be_valid_o = wr_valid_i;
        be_addr_o  = wr_addr_i;
        be_wdata_o = wr_wdata_i;
        be_wstrb_o = wr_wstrb_i;
        wr_ack_o   = be_ack_i;
      end
      READ: begin
        be_valid_o = rd_valid_i;
        be_addr_o  = rd_addr_i;
        rd_ack_o   = be_ack_i;
      end
      default: ;
    endcase
  end

  assign rd_rdata_o = be_rdata_i;
  assign busy_o     = (state_q != IDLE);

  // Counts write grants that jumped ahead of a waiting read; any read
  // grant, or an IDLE cycle without a read pending, starts it over.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_read || !rd_valid_i) begin
        starve_q <= '0;
      end else if (grant_write) begin
        starve_q <= starve_inc(starve_q);
      end
    end
  end

  // An ack nobody asked for, or a writer withdrawing before its ack,
  // means the two sides disagree about the transaction; flag it for good.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_o <= 1'b0;
    end else if ((state_q == IDLE && be_ack_i) ||
                 (state_q == WRITE && !wr_valid_i && !be_ack_i)) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_cache_be_arbiter_iob.sv
// Self-checking bench for iob_cache_be_arbiter_iob.
//
// Two arbiters share every input: one with strict write priority and
// one with RD_STARVE_MAX = 2. A per-instance ownership model predicts
// every output each cycle; directed scenarios add fixed expectations.
module tb_iob_cache_be_arbiter_iob;
  import iob_cache_be_arbiter_iob_pkg::*;

  localparam int AW = IOB_CACHE_IOB_BE_ADDR_W;
  localparam int DW = IOB_CACHE_IOB_BE_DATA_W;
  localparam int NB = DW / 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          rd_valid_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_busy_i;
  logic          wr_valid_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_wdata_i;
  logic [NB-1:0] wr_wstrb_i;
  logic          be_ack_i;
  logic [DW-1:0] be_rdata_i;

  logic          rd_ack_a, wr_ack_a, be_valid_a, busy_a, err_a;
  logic [DW-1:0] rd_rdata_a, be_wdata_a;
  logic [AW-1:0] be_addr_a;
  logic [NB-1:0] be_wstrb_a;
  logic          rd_ack_b, wr_ack_b, be_valid_b, busy_b, err_b;
  logic [DW-1:0] rd_rdata_b, be_wdata_b;
  logic [AW-1:0] be_addr_b;
  logic [NB-1:0] be_wstrb_b;

  always #5 clk_i = ~clk_i;

  iob_cache_be_arbiter_iob #(.BE_ADDR_W(AW), .BE_DATA_W(DW), .RD_STARVE_MAX(4'd0)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_busy_i(rd_busy_i),
    .rd_ack_o(rd_ack_a), .rd_rdata_o(rd_rdata_a),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
    .wr_wstrb_i(wr_wstrb_i), .wr_ack_o(wr_ack_a),
    .be_valid_o(be_valid_a), .be_addr_o(be_addr_a), .be_wdata_o(be_wdata_a),
    .be_wstrb_o(be_wstrb_a), .be_ack_i(be_ack_i), .be_rdata_i(be_rdata_i),
    .busy_o(busy_a), .err_o(err_a)
  );

  iob_cache_be_arbiter_iob #(.BE_ADDR_W(AW), .BE_DATA_W(DW), .RD_STARVE_MAX(4'd2)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_busy_i(rd_busy_i),
    .rd_ack_o(rd_ack_b), .rd_rdata_o(rd_rdata_b),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
    .wr_wstrb_i(wr_wstrb_i), .wr_ack_o(wr_ack_b),
    .be_valid_o(be_valid_b), .be_addr_o(be_addr_b), .be_wdata_o(be_wdata_b),
    .be_wstrb_o(be_wstrb_b), .be_ack_i(be_ack_i), .be_rdata_i(be_rdata_i),
    .busy_o(busy_b), .err_o(err_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner 0 = nobody, 1 = writer, 2 = reader.
  int owner[2];
  int starve[2];
  bit merr[2];
  int limit[2] = '{0, 2};

  int rd_ack_cnt_a;
  int wr_ack_cnt_b;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rv, input bit rb, input bit wv, input bit ack);
    rd_valid_i = rv;
    rd_busy_i  = rb;
    wr_valid_i = wv;
    be_ack_i   = ack;
  endtask

  task automatic check_model(input int d);
    logic          o_rd_ack, o_wr_ack, o_valid, o_busy, o_err;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rdata;
    logic [NB-1:0] o_wstrb;
    logic          e_rd_ack, e_wr_ack, e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [NB-1:0] e_wstrb;
    if (d == 0) begin
      o_rd_ack = rd_ack_a; o_wr_ack = wr_ack_a; o_valid = be_valid_a; o_busy = busy_a;
      o_err = err_a; o_addr = be_addr_a; o_wdata = be_wdata_a; o_rdata = rd_rdata_a;
      o_wstrb = be_wstrb_a;
    end else begin
      o_rd_ack = rd_ack_b; o_wr_ack = wr_ack_b; o_valid = be_valid_b; o_busy = busy_b;
      o_err = err_b; o_addr = be_addr_b; o_wdata = be_wdata_b; o_rdata = rd_rdata_b;
      o_wstrb = be_wstrb_b;
    end
    e_rd_ack = 1'b0; e_wr_ack = 1'b0; e_valid = 1'b0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    if (owner[d] == 1) begin
      e_valid = wr_valid_i; e_addr = wr_addr_i; e_wdata = wr_wdata_i;
      e_wstrb = wr_wstrb_i; e_wr_ack = be_ack_i;
    end else if (owner[d] == 2) begin
      e_valid = rd_valid_i; e_addr = rd_addr_i; e_rd_ack = be_ack_i;
    end
    check_output($sformatf("be_valid_%0d", d), 64'(o_valid), 64'(e_valid));
    check_output($sformatf("be_addr_%0d", d), 64'(o_addr), 64'(e_addr));
    check_output($sformatf("be_wdata_%0d", d), 64'(o_wdata), 64'(e_wdata));
    check_output($sformatf("be_wstrb_%0d", d), 64'(o_wstrb), 64'(e_wstrb));
    check_output($sformatf("rd_ack_%0d", d), 64'(o_rd_ack), 64'(e_rd_ack));
    check_output($sformatf("wr_ack_%0d", d), 64'(o_wr_ack), 64'(e_wr_ack));
    check_output($sformatf("rd_rdata_%0d", d), 64'(o_rdata), 64'(be_rdata_i));
    check_output($sformatf("busy_%0d", d), 64'(o_busy), 64'(owner[d] != 0));
    check_output($sformatf("err_%0d", d), 64'(o_err), 64'(merr[d]));
  endtask

  // Ownership rules evaluated with the inputs present at the clock edge.
  task automatic model_edge(input int d);
    bit read_first;
    case (owner[d])
      0: begin
        if (be_ack_i) merr[d] = 1'b1;
        read_first = rd_valid_i && (!wr_valid_i || (limit[d] > 0 && starve[d] >= limit[d]));
        if (read_first) begin
          owner[d]  = 2;
          starve[d] = 0;
        end else if (wr_valid_i) begin
          owner[d]  = 1;
          starve[d] = rd_valid_i ? ((starve[d] < 15) ? starve[d] + 1 : 15) : 0;
        end else begin
          starve[d] = 0;
        end
      end
      1: begin
        if (!wr_valid_i && !be_ack_i) merr[d] = 1'b1;
        if (be_ack_i) owner[d] = 0;
      end
      default: begin
        if (!rd_busy_i) owner[d] = 0;
      end
    endcase
  endtask

  // One clock: compare both instances mid-cycle, then advance the models.
  task automatic cycle();
    if (reset_i) begin
      for (int d = 0; d < 2; d++) begin
        owner[d] = 0; starve[d] = 0; merr[d] = 1'b0;
      end
    end
    #1;
    check_model(0);
    check_model(1);
    if (rd_ack_a) rd_ack_cnt_a++;
    if (wr_ack_b) wr_ack_cnt_b++;
    @(posedge clk_i);
    if (!reset_i) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    rd_addr_i = '0; wr_addr_i = '0; wr_wdata_i = '0; wr_wstrb_i = '0;
    be_rdata_i = 32'hA5A5_0001;
    for (int d = 0; d < 2; d++) begin
      owner[d] = 0; starve[d] = 0; merr[d] = 1'b0;
    end

    // Reset state
    @(negedge clk_i);
    #1;
    check_output("reset_be_valid", 64'(be_valid_a), 64'd0);
    check_output("reset_busy", 64'(busy_b), 64'd0);
    check_output("reset_rdata", 64'(rd_rdata_a), 64'hA5A5_0001);
    cycle();
    reset_i = 1'b0;
    cycle();

    // Single write, acked on its third WRITE cycle
    wr_addr_i = 24'h40; wr_wdata_i = 32'hDEAD_BEEF; wr_wstrb_i = 4'hF;
    apply_stimulus(0, 0, 1, 0);
    #1; check_output("wr_latency", 64'(be_valid_a), 64'd0);
    cycle();
    #1; check_output("wr_fwd_wstrb", 64'(be_wstrb_a), 64'hF);
    check_output("wr_fwd_addr", 64'(be_addr_a), 64'h40);
    cycle();
    cycle();
    apply_stimulus(0, 0, 1, 1);
    #1; check_output("wr_ack", 64'(wr_ack_a), 64'd1);
    cycle();
    apply_stimulus(0, 0, 0, 0);
    #1; check_output("wr_done_busy", 64'(busy_a), 64'd0);
    cycle();

    // Four-beat line fill with a write arriving mid-fill
    rd_addr_i = 24'h100; wr_addr_i = 24'h200; wr_wstrb_i = 4'h3;
    rd_ack_cnt_a = 0;
    apply_stimulus(1, 0, 0, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1, 1, i >= 2, (i >= 1) && (i <= 4));
      cycle();
    end
    apply_stimulus(1, 0, 1, 0);
    #1; check_output("fill_held", 64'(busy_a), 64'd1);
    check_output("fill_addr", 64'(be_addr_a), 64'h100);
    check_output("fill_acks", 64'(rd_ack_cnt_a), 64'd4);
    cycle();
    apply_stimulus(0, 0, 1, 0);
    #1; check_output("fill_release", 64'(busy_a), 64'd0);
    cycle();
    apply_stimulus(0, 0, 1, 1);
    #1; check_output("fill_then_write", 64'(be_wstrb_a), 64'h3);
    cycle();
    apply_stimulus(0, 0, 0, 0);
    cycle();

    // Simultaneous requests: write first, read after one bubble
    rd_addr_i = 24'h300; wr_addr_i = 24'h304; wr_wstrb_i = 4'h5;
    apply_stimulus(1, 0, 1, 0);
    cycle();
    apply_stimulus(1, 0, 1, 1);
    #1; check_output("both_write_first", 64'(be_addr_a), 64'h304);
    cycle();
    apply_stimulus(1, 0, 0, 0);
    #1; check_output("both_bubble", 64'(busy_a), 64'd0);
    cycle();
    apply_stimulus(1, 0, 0, 1);
    #1; check_output("both_read_second", 64'(be_addr_a), 64'h300);
    check_output("both_read_ack", 64'(rd_ack_a), 64'd1);
    cycle();
    apply_stimulus(0, 0, 0, 0);
    cycle();

    // Starvation limit of 2 with a write queue and a pending read
    rd_addr_i = 24'h500; wr_addr_i = 24'h600; wr_wstrb_i = 4'hC;
    wr_ack_cnt_b = 0;
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1, 0, 1, k[0]);
      #1;
      if (k == 5) begin
        check_output("starve_read_b", 64'(be_addr_b), 64'h500);
        check_output("starve_writes_b", 64'(wr_ack_cnt_b), 64'd2);
        check_output("strict_write_a", 64'(be_addr_a), 64'h600);
      end
      if (k == 11) check_output("starve_cleared_b", 64'(be_addr_b), 64'h500);
      cycle();
    end
    apply_stimulus(0, 0, 0, 0);
    cycle();

    // Unsolicited ack in IDLE sets a sticky error
    check_output("err_clear_before", 64'(err_a), 64'd0);
    apply_stimulus(0, 0, 0, 1);
    cycle();
    apply_stimulus(0, 0, 0, 0);
    #1; check_output("err_set", 64'(err_a), 64'd1);
    cycle();
    cycle();
    #1; check_output("err_sticky", 64'(err_b), 64'd1);

    // Reset during the second read beat
    rd_addr_i = 24'h700;
    apply_stimulus(1, 1, 0, 0);
    cycle();
    apply_stimulus(1, 1, 0, 1);
    cycle();
    reset_i = 1'b1;
    #1; check_output("rst_mid_valid", 64'(be_valid_a), 64'd0);
    check_output("rst_mid_ack", 64'(rd_ack_a), 64'd0);
    check_output("rst_mid_err", 64'(err_a), 64'd0);
    check_output("rst_mid_busy", 64'(busy_b), 64'd0);
    cycle();
    reset_i = 1'b0;
    apply_stimulus(0, 0, 0, 0);
    cycle();

    // Random traffic, including occasional resets
    for (int n = 0; n < 500; n++) begin
      reset_i    = ($urandom_range(0, 49) == 0);
      rd_addr_i  = AW'($urandom);
      wr_addr_i  = AW'($urandom);
      wr_wdata_i = $urandom;
      wr_wstrb_i = NB'($urandom);
      be_rdata_i = $urandom;
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
